// File: rtl/pipeline_stage_memory.sv
// pipeline_stage_memory
// Fourth pipeline stage. Takes the EX result registers, runs data-memory
// loads/stores over a req/ack handshake, formats load data into the MEM
// result registers and publishes the forwarding record for write-back.
//
// State table
//   state | meaning
//   IDLE  | no access in flight; aligned mem op issues a request and stalls
//   WAIT  | request outstanding, dm_* held stable, stall until dm_ack
//   RESP  | read data captured; MEM registers load the access result
//
// Ports
//   clock, reset             stage clock (rising), async active-low reset
//   ex_*                     EX-stage result registers (instruction in MEM)
//   dm_req/we/addr/wdata/byte_en, dm_ack, dm_rdata   data-memory handshake
//   stall_from_memory        upstream hold while an access is outstanding
//   mem_*                    MEM result registers feeding write-back
//   fwd_*                    forwarding record derived from MEM registers
module pipeline_stage_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ex_valid,
  input  logic [DATA_WIDTH-1:0]   ex_pc,
  input  logic                    ex_mem_read,
  input  logic                    ex_mem_write,
  input  logic [1:0]              ex_mem_size,
  input  logic                    ex_mem_signed,
  input  logic [DATA_WIDTH-1:0]   ex_dm_address,
  input  logic [DATA_WIDTH-1:0]   ex_store_data,
  input  logic [REG_ID_WIDTH-1:0] ex_reg_write_id,
  input  logic                    ex_reg_write_ready,
  input  logic [DATA_WIDTH-1:0]   ex_reg_write_data,
  output logic                    dm_req,
  output logic                    dm_we,
  output logic [DATA_WIDTH-1:0]   dm_addr,
  output logic [DATA_WIDTH-1:0]   dm_wdata,
  output logic [3:0]              dm_byte_en,
  input  logic                    dm_ack,
  input  logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    stall_from_memory,
  output logic                    mem_valid,
  output logic [DATA_WIDTH-1:0]   mem_pc,
  output logic                    mem_fault,
  output logic [REG_ID_WIDTH-1:0] mem_reg_write_id,
  output logic [DATA_WIDTH-1:0]   mem_reg_write_data,
  output logic [REG_ID_WIDTH-1:0] fwd_register_id,
  output logic                    fwd_data_ready,
  output logic [DATA_WIDTH-1:0]   fwd_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, nextState;
  logic                    isAccess, aligned, memOp, misaligned;
  logic [3:0]              storeByteEn;
  logic [DATA_WIDTH-1:0]   storeData;
  logic [DATA_WIDTH-1:0]   readDataReg;
  logic [DATA_WIDTH-1:0]   laneWord;
  logic [DATA_WIDTH-1:0]   loadData;

  always_comb begin
    isAccess = ex_valid && (ex_mem_read || ex_mem_write);
    case (ex_mem_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = !ex_dm_address[0];
      default: aligned = (ex_dm_address[1:0] == 2'b00);
    endcase
    memOp      = isAccess && aligned;
    misaligned = isAccess && !aligned;
  end

  // The request is registered, so stall is raised combinationally in the
  // issuing IDLE cycle to hold the same instruction in EX until RESP.
  assign stall_from_memory = ((state == IDLE) && memOp) || (state == WAIT);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (memOp) nextState = WAIT;
      WAIT:    if (dm_ack) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    case (ex_mem_size)
      2'd0: begin
        storeByteEn = 4'b0001 << ex_dm_address[1:0];
        storeData   = {4{ex_store_data[7:0]}};
      end
      2'd1: begin
        storeByteEn = 4'b0011 << ex_dm_address[1:0];
        storeData   = {2{ex_store_data[15:0]}};
      end
      default: begin
        storeByteEn = 4'b1111;
        storeData   = ex_store_data;
      end
    endcase
  end

  // Little-endian lane select: move the addressed lane down to bit 0.
  always_comb begin
    laneWord = readDataReg >> {ex_dm_address[1:0], 3'b000};
    case (ex_mem_size)
      2'd0:    loadData = {{(DATA_WIDTH-8){ex_mem_signed & laneWord[7]}}, laneWord[7:0]};
      2'd1:    loadData = {{(DATA_WIDTH-16){ex_mem_signed & laneWord[15]}}, laneWord[15:0]};
      default: loadData = readDataReg;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      dm_byte_en  <= '0;
      readDataReg <= '0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && memOp) begin
        dm_req     <= 1'b1;
        dm_we      <= ex_mem_write;
        dm_addr    <= {ex_dm_address[DATA_WIDTH-1:2], 2'b00};
        dm_wdata   <= storeData;
        dm_byte_en <= storeByteEn;
      end else if ((state == WAIT) && dm_ack) begin
        dm_req      <= 1'b0;
        readDataReg <= dm_rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_valid          <= 1'b0;
      mem_pc             <= '0;
      mem_fault          <= 1'b0;
      mem_reg_write_id   <= '0;
      mem_reg_write_data <= '0;
    end else if (stall_from_memory || !ex_valid) begin
      mem_valid <= 1'b0;
    end else begin
      mem_valid <= 1'b1;
      mem_pc    <= ex_pc;
      mem_fault <= misaligned;
      if (misaligned) begin
        mem_reg_write_id   <= '0;
        mem_reg_write_data <= ex_reg_write_data;
      end else if (ex_mem_read) begin
        // Only reachable in RESP: an aligned load in IDLE stalls instead.
        mem_reg_write_id   <= ex_reg_write_id;
        mem_reg_write_data <= loadData;
      end else begin
        mem_reg_write_id   <= ex_reg_write_id;
        mem_reg_write_data <= ex_reg_write_data;
      end
    end
  end

  always_comb begin
    fwd_data_ready  = 1'b1;
    fwd_register_id = '0;
    fwd_data        = '0;
    if (mem_valid) begin
      fwd_register_id = mem_reg_write_id;
      fwd_data        = mem_reg_write_data;
    end
  end

  // A non-load writing a register must arrive with its data already final.
  nonLoadReady: assert property (@(posedge clock) disable iff (!reset)
    (ex_valid && !stall_from_memory && !ex_mem_read && (ex_reg_write_id != '0))
      |-> ex_reg_write_ready);

endmodule

// File: tb/tb_pipeline_stage_memory.sv
module tb_pipeline_stage_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_signed, ex_reg_write_ready;
  logic [31:0] ex_pc, ex_dm_address, ex_store_data, ex_reg_write_data;
  logic [1:0]  ex_mem_size;
  logic [4:0]  ex_reg_write_id;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_byte_en;
  logic        stall_from_memory, mem_valid, mem_fault, fwd_data_ready;
  logic [31:0] mem_pc, mem_reg_write_data, fwd_data;
  logic [4:0]  mem_reg_write_id, fwd_register_id;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  id;
    logic [31:0] data;
    logic        fault;
    logic        checkData;
  } exp_t;

  exp_t sbQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clock = ~clock;

  pipeline_stage_memory dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size), .ex_mem_signed(ex_mem_signed),
    .ex_dm_address(ex_dm_address), .ex_store_data(ex_store_data),
    .ex_reg_write_id(ex_reg_write_id), .ex_reg_write_ready(ex_reg_write_ready),
    .ex_reg_write_data(ex_reg_write_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_byte_en(dm_byte_en), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_from_memory(stall_from_memory), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_fault(mem_fault), .mem_reg_write_id(mem_reg_write_id),
    .mem_reg_write_data(mem_reg_write_data), .fwd_register_id(fwd_register_id),
    .fwd_data_ready(fwd_data_ready), .fwd_data(fwd_data)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance one cycle and score whatever the MEM registers now hold.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    @(negedge clock);
    if (mem_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkVal("spurious_mem_valid", {31'b0, mem_valid}, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkVal("mem_pc", mem_pc, e.pc);
        checkVal("mem_reg_write_id", {27'b0, mem_reg_write_id}, {27'b0, e.id});
        checkVal("mem_fault", {31'b0, mem_fault}, {31'b0, e.fault});
        checkVal("fwd_register_id", {27'b0, fwd_register_id}, {27'b0, e.id});
        checkVal("fwd_data_ready", {31'b0, fwd_data_ready}, 32'd1);
        if (e.checkData) begin
          checkVal("mem_reg_write_data", mem_reg_write_data, e.data);
          checkVal("fwd_data", fwd_data, e.data);
        end
      end
    end else begin
      checkVal("fwd_idle_id", {27'b0, fwd_register_id}, 32'd0);
      checkVal("fwd_idle_data", fwd_data, 32'd0);
      checkVal("fwd_idle_ready", {31'b0, fwd_data_ready}, 32'd1);
    end
  endtask

  task automatic driveIdle();
    ex_valid = 0; ex_pc = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_size = 0;
    ex_mem_signed = 0; ex_dm_address = 0; ex_store_data = 0; ex_reg_write_id = 0;
    ex_reg_write_ready = 0; ex_reg_write_data = 0;
  endtask

  task automatic driveOp(input logic [31:0] pc, input logic rd, input logic wr,
                         input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] id,
                         input logic [31:0] regData);
    ex_valid = 1; ex_pc = pc; ex_mem_read = rd; ex_mem_write = wr; ex_mem_size = size;
    ex_mem_signed = sgn; ex_dm_address = addr; ex_store_data = sdata; ex_reg_write_id = id;
    ex_reg_write_ready = !rd; ex_reg_write_data = regData;
  endtask

  // Single-cycle instruction: ALU op or misaligned access (fault, no request).
  task automatic oneCycleOp(input logic [31:0] pc, input logic rd, input logic wr,
                            input logic [1:0] size, input logic [31:0] addr,
                            input logic [4:0] id, input logic [31:0] regData,
                            input logic expFault);
    exp_t e;
    driveOp(pc, rd, wr, size, 1'b0, addr, 32'h0, id, regData);
    #1;
    checkVal("stall_single", {31'b0, stall_from_memory}, 32'd0);
    e.pc = pc; e.id = expFault ? 5'd0 : id; e.data = regData;
    e.fault = expFault; e.checkData = !expFault;
    sbQ.push_back(e);
    tick();
    checkVal("no_dm_req_single", {31'b0, dm_req}, 32'd0);
    driveIdle();
  endtask

  // Aligned access; ack arrives in WAIT cycle waitN+1.
  task automatic memAccess(input logic [31:0] pc, input logic rd, input logic wr,
                           input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] id, input int waitN,
                           input logic [31:0] rdata, input logic [31:0] expAddr,
                           input logic [3:0] expBe, input logic [31:0] expWdata,
                           input logic [31:0] expData);
    exp_t e;
    int   stallCount;
    driveOp(pc, rd, wr, size, sgn, addr, sdata, id, rd ? 32'h0BAD0BAD : 32'h0);
    #1;
    checkVal("stall_issue", {31'b0, stall_from_memory}, 32'd1);
    stallCount = (stall_from_memory === 1'b1) ? 1 : 0;
    tick();
    for (int i = 0; i <= waitN; i++) begin
      checkVal("dm_req_wait", {31'b0, dm_req}, 32'd1);
      checkVal("dm_addr", dm_addr, expAddr);
      checkVal("dm_we", {31'b0, dm_we}, {31'b0, wr});
      checkVal("dm_byte_en", {28'b0, dm_byte_en}, {28'b0, expBe});
      if (wr) checkVal("dm_wdata", dm_wdata, expWdata);
      if (stall_from_memory === 1'b1) stallCount++;
      if (i == waitN) begin
        dm_ack = 1; dm_rdata = rdata;
      end
      tick();
      dm_ack = 0; dm_rdata = 32'h0;
    end
    checkVal("dm_req_drop", {31'b0, dm_req}, 32'd0);
    #1;
    checkVal("stall_resp", {31'b0, stall_from_memory}, 32'd0);
    checkVal("stall_cycles", stallCount, waitN + 2);
    e.pc = pc; e.id = id; e.data = expData; e.fault = 0; e.checkData = 1;
    sbQ.push_back(e);
    tick();
    driveIdle();
  endtask

  initial begin
    reset = 0; dm_ack = 0; dm_rdata = 0;
    driveIdle();
    tick();
    tick();
    checkVal("rst_dm_req", {31'b0, dm_req}, 32'd0);
    checkVal("rst_dm_addr", dm_addr, 32'd0);
    checkVal("rst_dm_byte_en", {28'b0, dm_byte_en}, 32'd0);
    checkVal("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    checkVal("rst_mem_pc", mem_pc, 32'd0);
    checkVal("rst_stall", {31'b0, stall_from_memory}, 32'd0);
    reset = 1;
    tick();

    oneCycleOp(32'h10, 0, 0, 2'd2, 32'h0, 5'd8, 32'h1234, 0);
    oneCycleOp(32'h14, 0, 0, 2'd2, 32'h0, 5'd3, 32'hCAFEF00D, 0);

    memAccess(32'h20, 1, 0, 2'd2, 0, 32'h100, 0, 5'd5, 2, 32'hDEADBEEF,
              32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    memAccess(32'h24, 1, 0, 2'd0, 1, 32'h103, 0, 5'd6, 0, 32'h80FFFFFF,
              32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    memAccess(32'h28, 1, 0, 2'd0, 0, 32'h103, 0, 5'd7, 1, 32'h80FFFFFF,
              32'h100, 4'b1000, 32'h0, 32'h00000080);
    memAccess(32'h2C, 0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 5'd0, 0, 32'h0,
              32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
    memAccess(32'h30, 0, 1, 2'd0, 0, 32'h001, 32'h1234565A, 5'd0, 1, 32'h0,
              32'h000, 4'b0010, 32'h5A5A5A5A, 32'h0);
    memAccess(32'h34, 0, 1, 2'd2, 0, 32'h300, 32'h11223344, 5'd0, 0, 32'h0,
              32'h300, 4'b1111, 32'h11223344, 32'h0);
    memAccess(32'h38, 1, 0, 2'd1, 1, 32'h402, 0, 5'd9, 0, 32'h80017F00,
              32'h400, 4'b1100, 32'h0, 32'hFFFF8001);
    memAccess(32'h3C, 1, 0, 2'd1, 0, 32'h400, 0, 5'd10, 0, 32'h80017F00,
              32'h400, 4'b0011, 32'h0, 32'h00007F00);
    memAccess(32'h40, 1, 0, 2'd3, 0, 32'h500, 0, 5'd11, 0, 32'h55AA55AA,
              32'h500, 4'b1111, 32'h0, 32'h55AA55AA);

    oneCycleOp(32'h44, 1, 0, 2'd2, 32'h102, 5'd12, 32'h0, 1);
    oneCycleOp(32'h48, 0, 1, 2'd1, 32'h201, 5'd0, 32'h0, 1);
    oneCycleOp(32'h4C, 0, 0, 2'd2, 32'h0, 5'd13, 32'h77, 0);

    // Reset while a request is outstanding, then a stray late ack.
    driveOp(32'h50, 1, 0, 2'd2, 0, 32'h600, 0, 5'd14, 32'h0);
    tick();
    checkVal("pre_rst_dm_req", {31'b0, dm_req}, 32'd1);
    #2;
    reset = 0;
    driveIdle();
    #1;
    checkVal("rst_wait_dm_req", {31'b0, dm_req}, 32'd0);
    checkVal("rst_wait_mem_valid", {31'b0, mem_valid}, 32'd0);
    checkVal("rst_wait_stall", {31'b0, stall_from_memory}, 32'd0);
    tick();
    reset = 1;
    dm_ack = 1; dm_rdata = 32'h12345678;
    tick();
    dm_ack = 0; dm_rdata = 0;
    checkVal("late_ack_dm_req", {31'b0, dm_req}, 32'd0);
    checkVal("late_ack_stall", {31'b0, stall_from_memory}, 32'd0);
    tick();
    checkVal("late_ack_mem_valid", {31'b0, mem_valid}, 32'd0);

    oneCycleOp(32'h54, 0, 0, 2'd2, 32'h0, 5'd15, 32'hA5A5A5A5, 0);
    tick();
    checkVal("queue_drained", sbQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_memory.md
Name: pipeline_stage_memory

Overview:
- Fourth pipeline stage. It consumes the execution-stage result registers, performs data-memory loads and stores over a req/ack handshake, and formats load data.
- It drives the memory-stage result registers that feed write-back.
- It publishes the forwarding record for the instruction now past memory (register id, ready, data), and stalls upstream while a memory access is outstanding.

Parameters:
- DATA_WIDTH, 32, data/address width; must be 32 (byte-lane logic assumes 4 lanes).
- REG_ID_WIDTH, 5, register-id width.

Ports:
- clock  in  1  stage clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX result is a real instruction, not a bubble.
- ex_pc  in  32  program counter of the EX instruction.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store (never both with ex_mem_read).
- ex_mem_size  in  2  access size: 0 byte, 1 half, 2 word; 3 is illegal and treated as word.
- ex_mem_signed  in  1  sign-extend load data.
- ex_dm_address  in  32  byte address (EX ALU result).
- ex_store_data  in  32  store data (forwarded rt).
- ex_reg_write_id  in  5  destination register; 0 means none.
- ex_reg_write_ready  in  1  ex_reg_write_data is final.
- ex_reg_write_data  in  32  write data produced in EX.
- dm_req  out  1  memory request.
- dm_we  out  1  request is a write.
- dm_addr  out  32  word address, {addr[31:2],2'b00}.
- dm_wdata  out  32  lane-shifted store data.
- dm_byte_en  out  4  byte enables.
- dm_ack  in  1  request completed this cycle.
- dm_rdata  in  32  read word; valid when dm_ack=1.
- stall_from_memory  out  1  upstream must hold.
- mem_valid  out  1  MEM result is a real instruction.
- mem_pc  out  32  PC of the MEM result.
- mem_fault  out  1  misaligned access.
- mem_reg_write_id  out  5  write-back register id.
- mem_reg_write_data  out  32  write-back data.
- fwd_register_id  out  5  forwarding record: register id.
- fwd_data_ready  out  1  forwarding record: data ready.
- fwd_data  out  32  forwarding record: data.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_byte_en=0. mem_valid=0, mem_fault=0, mem_pc=0, mem_reg_write_id=0, mem_reg_write_data=0. An in-flight request is abandoned; an ack arriving after reset release is ignored in IDLE.
- mem_op = ex_valid && (ex_mem_read || ex_mem_write) && aligned.
- aligned: byte always; half requires addr[0]=0; word requires addr[1:0]=0.
- FSM IDLE:
  - If mem_op: register the request (dm_req<=1 plus dm_we/addr/wdata/byte_en); go to WAIT; stall_from_memory=1 this cycle.
  - Otherwise no stall.
- FSM WAIT:
  - dm_req and all dm_* outputs held stable.
  - stall_from_memory=1.
  - On dm_ack=1: capture dm_rdata, drop dm_req next edge, go to RESP.
  - No timeout; waits indefinitely.
- FSM RESP:
  - stall_from_memory=0.
  - MEM result registers load the formatted access result at the end of this cycle; go to IDLE.
  - The EX inputs still describe the same instruction in this cycle.
- Latency: non-memory instruction 1 cycle. Memory access 3 + N cycles, where N = WAIT cycles before ack; zero-wait memory (ack in the first WAIT cycle) gives a 3-cycle occupancy with 2 stall cycles.
- Stores:
  - byte: byte_en = 1 << addr[1:0], wdata = {4{data[7:0]}}.
  - half: byte_en = 4'b0011 << addr[1:0], wdata = {2{data[15:0]}}.
  - word: byte_en = 4'b1111, wdata = data.
- Loads:
  - Select the lane by addr[1:0], little-endian.
  - Sign- or zero-extend to 32 bits per ex_mem_signed.
  - The result replaces ex_reg_write_data.
- Misaligned memory op:
  - No request issued, no stall.
  - MEM result gets mem_fault=1 and mem_reg_write_id=0; the store is suppressed.
- MEM result registers (updated every clock; write-back never stalls):
  - If stall_from_memory or !ex_valid: mem_valid<=0, others hold.
  - Else: mem_valid<=1, mem_pc<=ex_pc, mem_reg_write_id and mem_reg_write_data loaded, mem_fault loaded.
  - Non-load with ex_reg_write_ready=0 is a decode bug; an assertion is required.
- Forwarding record (combinational from MEM result registers):
  - If !mem_valid: id=0, ready=1, data=0.
  - Else: id=mem_reg_write_id, ready=1, data=mem_reg_write_data.
- Simultaneous events:
  - dm_ack in the same cycle as entering WAIT is not possible; the request is registered.
  - ack while in IDLE or RESP is ignored.

Test Plan:
- ALU op with id=8, data=0x1234, ready=1 → next cycle mem_valid=1, fwd id=8, data=0x1234; no dm_req and no stall.
- Word load from 0x100 with ack after 3 WAIT cycles and rdata=0xDEADBEEF → stall high for 4 cycles, dm_addr=0x100 held stable, then mem_reg_write_data=0xDEADBEEF.
- Signed byte load from 0x103 with rdata=0x80FFFFFF → data=0xFFFFFF80; unsigned → 0x00000080.
- Half store of 0xABCD to 0x202 → dm_we=1, dm_byte_en=4'b1100, dm_wdata=0xABCDABCD, dm_addr=0x200.
- Word load from 0x102 → no dm_req, no stall, mem_fault=1, mem_reg_write_id=0.
- reset=0 asserted in WAIT → dm_req=0 immediately, state IDLE, mem_valid=0; a late dm_ack after release produces no output change.
